slow_clk_monitor: RTL and testbench



---
 rtl/slow_clk_monitor.sv | 119 +++++++++++
 tb/tb_slow_clk_monitor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: synchronises a slow clock/toggle into clk, emits edge
// ticks, measures period and high time, and flags a stall when it stops.
module slow_clk_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_in,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             stall
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_LOCK
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_ONE  = CNT_W'(1);

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_period;
  logic [CNT_W-1:0]       r_high;
  logic                   r_valid;

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic             w_active;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_prev;
  assign w_fall    = ~w_s & r_prev;
  assign w_active  = (r_state != ST_IDLE);
  assign w_cnt_inc = r_cnt + LP_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], slow_in};
      r_prev <= w_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A rise arriving on the timeout cycle takes priority over the stall.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rise) w_next = ST_ARM;
      end
      ST_ARM, ST_LOCK: begin
        if (w_rise) begin
          w_next = ST_LOCK;
        end else if (r_cnt == LP_LAST) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_period <= '0;
      r_high   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_active && w_fall) r_high <= w_cnt_inc;
      if (w_rise) begin
        r_cnt <= '0;
        if (w_active) begin
          r_period <= w_cnt_inc;
          r_valid  <= 1'b1;
        end
      end else if (w_timeout) begin
        r_cnt   <= '0;
        r_valid <= 1'b0;
      end else if (w_active) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign rise_tick    = w_rise;
  assign fall_tick    = w_fall;
  assign period       = r_period;
  assign high_time    = r_high;
  assign period_valid = r_valid;
  assign stall        = w_timeout;

endmodule

// File: tb/tb_slow_clk_monitor.sv
// tb_slow_clk_monitor: random square waves against an event-time model,
// expectations queued by the driver and checked by an independent monitor.
module tb_slow_clk_monitor;

  localparam int SS = 2;
  localparam int CW = 8;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          slow_in = 1'b0;
  logic          rise_tick;
  logic          fall_tick;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_valid;
  logic          stall;

  slow_clk_monitor #(
    .SYNC_STAGES(SS),
    .CNT_W(CW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .slow_in(slow_in),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .period(period),
    .high_time(high_time),
    .period_valid(period_valid),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rise;
    bit fall;
    bit stall;
    bit valid;
    int period;
    int high;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail = 0;
  bit   running = 1'b0;

  // Model: input history (sync delay), last rise time, lock flags.
  bit   h1, h2;
  bit   armed, m_valid;
  int   m_period, m_high, last_rise, cyc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    h1 = 0; h2 = 0; armed = 0; m_valid = 0;
    m_period = 0; m_high = 0; last_rise = 0; cyc = 0;
  endtask

  task automatic push_expect(input bit v);
    exp_t e;
    bit r, f, st;
    r  = h1 & ~h2;
    f  = ~h1 & h2;
    st = armed && !r && ((cyc - last_rise) == TO);
    e.rise = r; e.fall = f; e.stall = st;
    e.valid = m_valid; e.period = m_period; e.high = m_high;
    sbq.push_back(e);
    if (armed && f) m_high = cyc - last_rise;
    if (r) begin
      if (armed) begin
        m_period = cyc - last_rise;
        m_valid  = 1;
      end
      armed = 1;
      last_rise = cyc;
    end else if (st) begin
      armed = 0;
      m_valid = 0;
    end
    h2 = h1;
    h1 = v;
    cyc++;
  endtask

  // Each step starts at a negedge: apply level, queue expectation, wait.
  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      slow_in = v;
      push_expect(v);
      @(negedge clk);
    end
  endtask

  task automatic wave(input int p, input int h, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      drive(1'b1, h);
      drive(1'b0, p - h);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rise"}, rise_tick, 0);
    chk({tag, "_fall"}, fall_tick, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high"}, high_time, 0);
    chk({tag, "_valid"}, period_valid, 0);
    chk({tag, "_stall"}, stall, 0);
  endtask

  // Asserted between edges; outputs must clear without a clock edge.
  task automatic reset_dut(input bit lvl);
    #2;
    rst = 1'b1;
    running = 1'b0;
    #1;
    check_zero("async_rst");
    sbq.delete();
    slow_in = lvl;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    running = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (running && !rst) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL queue_empty t=%0t: got 0 entries, expected 1", $time);
        end else begin
          e = sbq.pop_front();
          chk("rise_tick", rise_tick, e.rise);
          chk("fall_tick", fall_tick, e.fall);
          chk("stall", stall, e.stall);
          chk("period_valid", period_valid, e.valid);
          chk("period", period, e.period);
          chk("high_time", high_time, e.high);
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int p, h;
    model_clear();
    repeat (2) @(negedge clk);
    check_zero("in_reset");
    @(negedge clk);
    rst = 1'b0;
    running = 1'b1;

    drive(1'b0, 300);
    wave(10, 4, 6);
    drive(1'b0, 250);
    wave(10, 4, 3);
    wave(14, 5, 3);
    wave(10, 4, 2);
    wave(200, 4, 2);
    wave(199, 7, 2);
    wave(201, 3, 2);
    wave(10, 4, 2);

    for (int k = 0; k < 40; k++) begin
      p = int'($urandom_range(6, 90));
      h = int'($urandom_range(3, p - 3));
      wave(p, h, int'($urandom_range(1, 4)));
      if ($urandom_range(0, 4) == 0)
        drive(1'b0, int'($urandom_range(150, 260)));
    end

    wave(10, 4, 4);
    reset_dut(1'b1);
    drive(1'b1, 4);
    drive(1'b0, 196);
    drive(1'b1, 4);
    drive(1'b0, 10);
    wave(10, 4, 3);
    reset_dut(1'b0);
    drive(1'b0, 300);

    chk("queue_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
